// File: rtl/crc9_128_pkg.sv
// Shared constants, FSM state type and parity-check column table for the 128-bit CRC-9 decoder.
// Column vectors use bit k as the x^k coefficient: H_COL[i] = x^(9+i) mod g(x).
package crc9_128_pkg;

   localparam int unsigned CRC9_W = 9;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned CODE_W = 137;
   localparam int unsigned DIDX_W = 7;

   // g(x) = x^9 + x^8 + x^5 + x^2 + x + 1, leading term dropped
   localparam logic [0:CRC9_W-1] G_LOW = 9'b111001001;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYND   = 2'd1,
      SEARCH = 2'd2,
      OUT    = 2'd3
   } state_e;

   typedef logic [0:DATA_W-1][0:CRC9_W-1] hcol_tbl_t;

   function automatic hcol_tbl_t gen_h_col();
      hcol_tbl_t         tbl;
      logic [0:CRC9_W-1] col;
      tbl = '0;
      col = G_LOW;
      for (int i = 0; i < int'(DATA_W); i++) begin
         tbl[DIDX_W'(i)] = col;
         col = {1'b0, col[0:CRC9_W-2]} ^ (col[CRC9_W-1] ? G_LOW : '0);
      end
      return tbl;
   endfunction

   localparam hcol_tbl_t H_COL = gen_h_col();

   function automatic logic is_onehot9(input logic [0:CRC9_W-1] s);
      return (s != '0) && ((s & (s - 9'd1)) == '0);
   endfunction

endpackage

// File: rtl/crc9_chunk_fold.sv
// Combinational XOR of the H_COL columns for the set bits of data chunk k.
module crc9_chunk_fold
   import crc9_128_pkg::*;
#(
   parameter int unsigned CHUNK = 16,
   parameter int unsigned KW    = 3
) (
   input  logic [0:DATA_W-1] data_i,
   input  logic [KW-1:0]     k_i,
   output logic [0:CRC9_W-1] fold_o
);

   logic [DIDX_W-1:0] idx;

   always_comb begin
      fold_o = '0;
      idx    = '0;
      for (int j = 0; j < int'(CHUNK); j++) begin
         idx = DIDX_W'(int'(k_i) * int'(CHUNK) + j);
         if (data_i[idx]) fold_o = fold_o ^ H_COL[idx];
      end
   end

endmodule

// File: rtl/crc9_128_dec.sv
// Multi-cycle CRC-9 syndrome check over a 137-bit codeword with optional single-bit correction.
// One codeword in flight; results held in a registered output stage until accepted.
module crc9_128_dec
   import crc9_128_pkg::*;
#(
   parameter int unsigned CHUNK   = 16,
   parameter int unsigned CORRECT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [0:CODE_W-1] i_code,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [0:DATA_W-1] o_data,
   output logic [0:CRC9_W-1] o_syndrome,
   output logic              o_err,
   output logic              o_corrected,
   output logic              o_uncorrectable
);

   localparam int unsigned   N      = DATA_W / CHUNK;
   localparam int unsigned   KW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   state_e            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [0:DATA_W-1] data_q, data_d;
   logic [0:CRC9_W-1] syn_q, syn_d;
   logic [0:CRC9_W-1] syn_nx, fold;
   logic              corr_q, corr_d;
   logic              unc_q, unc_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [0:DATA_W-1] odata_q, odata_d;
   logic [0:CRC9_W-1] osyn_q, osyn_d;
   logic              oerr_q, oerr_d;
   logic              ocorr_q, ocorr_d;
   logic              ounc_q, ounc_d;
   logic              hit;
   logic [DIDX_W-1:0] hit_idx, cand_idx;

   crc9_chunk_fold #(
      .CHUNK (CHUNK),
      .KW    (KW)
   ) u_fold (
      .data_i (data_q),
      .k_i    (k_q),
      .fold_o (fold)
   );

   // Column search for chunk k; scanning downwards leaves the lowest matching index
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      cand_idx = '0;
      for (int j = int'(CHUNK) - 1; j >= 0; j--) begin
         cand_idx = DIDX_W'(int'(k_q) * int'(CHUNK) + j);
         if (H_COL[cand_idx] == syn_q) begin
            hit     = 1'b1;
            hit_idx = cand_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      data_d  = data_q;
      syn_d   = syn_q;
      corr_d  = corr_q;
      unc_d   = unc_q;
      valid_d = valid_q;
      odata_d = odata_q;
      osyn_d  = osyn_q;
      oerr_d  = oerr_q;
      ocorr_d = ocorr_q;
      ounc_d  = ounc_q;
      syn_nx  = syn_q ^ fold;

      unique case (state_q)
         IDLE: begin
            if (i_valid && ready_q) begin
               data_d  = i_code[CRC9_W +: DATA_W];
               syn_d   = i_code[0 +: CRC9_W];
               k_d     = '0;
               corr_d  = 1'b0;
               unc_d   = 1'b0;
               state_d = SYND;
            end
         end
         SYND: begin
            syn_d = syn_nx;
            if (k_q != K_LAST) begin
               k_d = k_q + KW'(1);
            end else if (syn_nx == '0) begin
               state_d = OUT;
            end else if (CORRECT == 0) begin
               unc_d   = 1'b1;
               state_d = OUT;
            end else if (is_onehot9(syn_nx)) begin
               // lone parity-bit error: data is already good
               corr_d  = 1'b1;
               state_d = OUT;
            end else begin
               k_d     = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               data_d[hit_idx] = ~data_q[hit_idx];
               corr_d          = 1'b1;
               state_d         = OUT;
            end else if (k_q == K_LAST) begin
               unc_d   = 1'b1;
               state_d = OUT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         OUT: begin
            // first cycle loads the output stage, then hold until accepted
            if (!valid_q) begin
               valid_d = 1'b1;
               odata_d = data_q;
               osyn_d  = syn_q;
               oerr_d  = (syn_q != '0);
               ocorr_d = corr_q;
               ounc_d  = unc_q;
            end else if (i_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         data_q  <= '0;
         syn_q   <= '0;
         corr_q  <= 1'b0;
         unc_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         odata_q <= '0;
         osyn_q  <= '0;
         oerr_q  <= 1'b0;
         ocorr_q <= 1'b0;
         ounc_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         data_q  <= data_d;
         syn_q   <= syn_d;
         corr_q  <= corr_d;
         unc_q   <= unc_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         odata_q <= odata_d;
         osyn_q  <= osyn_d;
         oerr_q  <= oerr_d;
         ocorr_q <= ocorr_d;
         ounc_q  <= ounc_d;
      end
   end

   assign o_ready         = ready_q;
   assign o_valid         = valid_q;
   assign o_data          = odata_q;
   assign o_syndrome      = osyn_q;
   assign o_err           = oerr_q;
   assign o_corrected     = ocorr_q;
   assign o_uncorrectable = ounc_q;

endmodule

// File: tb/tb_crc9_128_dec.sv
// Scoreboard bench for crc9_128_dec: a serial long-division CRC model predicts each result.
// A second instance with correction disabled covers detect-only behaviour.
module tb_crc9_128_dec;

   localparam int unsigned CHUNK = 16;
   localparam int          N     = 128 / 16;
   localparam logic [0:8]  G_LOW = 9'b111001001;

   typedef struct {
      logic [0:127] data;
      logic [0:8]   syn;
      logic         err;
      logic         corr;
      logic         unc;
      int           lat;
      int           hold;
      int           t_acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         i_valid, o_ready, o_valid, i_ready;
   logic [0:136] i_code;
   logic [0:127] o_data;
   logic [0:8]   o_syndrome;
   logic         o_err, o_corrected, o_uncorrectable;

   logic         nc_i_valid, nc_o_ready, nc_o_valid, nc_i_ready;
   logic [0:136] nc_i_code;
   logic [0:127] nc_o_data;
   logic [0:8]   nc_o_syndrome;
   logic         nc_o_err, nc_o_corrected, nc_o_uncorrectable;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   logic [0:8]   mcol [0:127];
   exp_t         sb_q [$];

   bit           mon_seen, mon_drop;
   int           mon_hold;
   exp_t         mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   crc9_128_dec #(.CHUNK(CHUNK), .CORRECT(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_valid(i_valid), .o_ready(o_ready), .i_code(i_code),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_syndrome(o_syndrome), .o_err(o_err),
      .o_corrected(o_corrected), .o_uncorrectable(o_uncorrectable)
   );

   crc9_128_dec #(.CHUNK(CHUNK), .CORRECT(0)) dut_nc (
      .clk(clk), .reset_n(reset_n),
      .i_valid(nc_i_valid), .o_ready(nc_o_ready), .i_code(nc_i_code),
      .o_valid(nc_o_valid), .i_ready(nc_i_ready),
      .o_data(nc_o_data), .o_syndrome(nc_o_syndrome), .o_err(nc_o_err),
      .o_corrected(nc_o_corrected), .o_uncorrectable(nc_o_uncorrectable)
   );

   task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bit-serial long division: sum of data[i]*x^(9+i) mod g
   function automatic logic [0:8] model_crc(input logic [0:127] d);
      logic [0:8] r;
      logic       fb;
      r = '0;
      for (int i = 127; i >= 0; i--) begin
         fb = r[8] ^ d[i];
         r  = {1'b0, r[0:7]};
         if (fb) r = r ^ G_LOW;
      end
      return r;
   endfunction

   function automatic exp_t mk(input logic [0:127] d, input logic [0:8] s, input logic err,
                               input logic corr, input logic unc, input int lat, input int hold);
      exp_t e;
      e.data = d; e.syn = s; e.err = err; e.corr = corr; e.unc = unc;
      e.lat = lat; e.hold = hold; e.t_acc = 0;
      return e;
   endfunction

   function automatic exp_t model_dec(input logic [0:136] c, input bit correct);
      exp_t       e;
      logic [0:8] s;
      e = mk(c[9:136], '0, 1'b0, 1'b0, 1'b0, N + 1, 0);
      s = c[0:8] ^ model_crc(e.data);
      e.syn = s;
      e.err = (s != '0);
      if (s != '0) begin
         if (!correct) e.unc = 1'b1;
         else if ($countones(s) == 1) e.corr = 1'b1;
         else begin
            e.unc = 1'b1;
            e.lat = 2 * N + 1;
            for (int i = 0; i < 128; i++) begin
               if (mcol[i] == s) begin
                  e.data[i] = ~e.data[i];
                  e.corr    = 1'b1;
                  e.unc     = 1'b0;
                  e.lat     = N + 1 + i / int'(CHUNK) + 1;
                  break;
               end
            end
         end
      end
      return e;
   endfunction

   task automatic wait_idle();
      int t = 0;
      while (!(o_ready && sb_q.size() == 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         check_eq("idle_timeout_ready", 160'(o_ready), 160'(1));
         check_eq("idle_timeout_queue", 160'(sb_q.size()), 160'(0));
      end
   endtask

   task automatic send_exp(input logic [0:136] c, input exp_t e);
      exp_t ex;
      wait_idle();
      ex       = e;
      ex.t_acc = cyc + 1;
      sb_q.push_back(ex);
      i_code  = c;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      i_code  = ~c;
   endtask

   task automatic send_model(input logic [0:136] c, input int hold);
      exp_t e;
      e      = model_dec(c, 1'b1);
      e.hold = hold;
      send_exp(c, e);
   endtask

   task automatic nc_run(input logic [0:136] c, input exp_t e);
      int t0;
      int t;
      check_eq("nc_ready", 160'(nc_o_ready), 160'(1));
      nc_i_code  = c;
      nc_i_valid = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      nc_i_valid = 1'b0;
      nc_i_code  = ~c;
      t = 0;
      while (!nc_o_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check_eq("nc_valid", 160'(nc_o_valid), 160'(1));
      check_eq("nc_latency", 160'(cyc - t0), 160'(e.lat));
      check_eq("nc_data", 160'(nc_o_data), 160'(e.data));
      check_eq("nc_syn", 160'(nc_o_syndrome), 160'(e.syn));
      check_eq("nc_err", 160'(nc_o_err), 160'(e.err));
      check_eq("nc_corr", 160'(nc_o_corrected), 160'(e.corr));
      check_eq("nc_unc", 160'(nc_o_uncorrectable), 160'(e.unc));
      @(negedge clk);
      check_eq("nc_drop", 160'(nc_o_valid), 160'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, 160'(o_valid), 160'(0));
      check_eq({tag, "_ready"}, 160'(o_ready), 160'(1));
      check_eq({tag, "_data"}, 160'(o_data), 160'(0));
      check_eq({tag, "_syn"}, 160'(o_syndrome), 160'(0));
      check_eq({tag, "_flags"}, 160'({o_err, o_corrected, o_uncorrectable}), 160'(0));
      check_eq({tag, "_nc_ready"}, 160'(nc_o_ready), 160'(1));
   endtask

   // Monitor: checks latency and payload, applies backpressure, pops on handshake
   initial begin
      i_ready  = 1'b0;
      mon_seen = 1'b0;
      mon_drop = 1'b0;
      mon_hold = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            i_ready  = 1'b0;
            mon_seen = 1'b0;
            mon_drop = 1'b0;
         end else if (mon_drop) begin
            check_eq("valid_drop", 160'(o_valid), 160'(0));
            check_eq("ready_back", 160'(o_ready), 160'(1));
            mon_drop = 1'b0;
            i_ready  = 1'b0;
         end else if (o_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("spurious_valid", 160'(o_valid), 160'(0));
               i_ready = 1'b1;
            end else begin
               mon_e = sb_q[0];
               if (!mon_seen) begin
                  mon_seen = 1'b1;
                  mon_hold = mon_e.hold;
                  check_eq("latency", 160'(cyc - mon_e.t_acc), 160'(mon_e.lat));
               end
               check_eq("data", 160'(o_data), 160'(mon_e.data));
               check_eq("syndrome", 160'(o_syndrome), 160'(mon_e.syn));
               check_eq("err", 160'(o_err), 160'(mon_e.err));
               check_eq("corrected", 160'(o_corrected), 160'(mon_e.corr));
               check_eq("uncorrectable", 160'(o_uncorrectable), 160'(mon_e.unc));
               check_eq("busy_ready", 160'(o_ready), 160'(0));
               if (mon_hold > 0) begin
                  mon_hold--;
                  i_ready = 1'b0;
               end else begin
                  i_ready = 1'b1;
                  void'(sb_q.pop_front());
                  mon_seen = 1'b0;
                  mon_drop = 1'b1;
               end
            end
         end else if (sb_q.size() > 0 && (cyc - sb_q[0].t_acc) > 400) begin
            check_eq("valid_timeout", 160'(o_valid), 160'(1));
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      logic [0:127] d;
      logic [0:136] c;
      int           b, b2;

      reset_n    = 1'b0;
      i_valid    = 1'b0;
      i_code     = '0;
      nc_i_valid = 1'b0;
      nc_i_code  = '0;
      nc_i_ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         d       = '0;
         d[i]    = 1'b1;
         mcol[i] = model_crc(d);
      end

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // all-zero codeword
      c = '0;
      send_exp(c, mk('0, 9'b000000000, 1'b0, 1'b0, 1'b0, N + 1, 0));

      // clean encoded word, then same word under 5 cycles of backpressure
      d = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
      c = {model_crc(d), d};
      send_exp(c, mk(d, 9'b000000000, 1'b0, 1'b0, 1'b0, N + 1, 0));
      send_exp(c, mk(d, 9'b000000000, 1'b0, 1'b0, 1'b0, N + 1, 5));

      // single data-bit errors at both ends, single parity-bit error
      c = '0; c[9] = 1'b1;
      send_exp(c, mk('0, 9'b111001001, 1'b1, 1'b1, 1'b0, N + 2, 0));
      c = '0; c[10] = 1'b1;
      send_exp(c, mk('0, 9'b100101101, 1'b1, 1'b1, 1'b0, N + 2, 0));
      c = '0; c[136] = 1'b1;
      send_exp(c, mk('0, mcol[127], 1'b1, 1'b1, 1'b0, 17, 0));
      c = '0; c[4] = 1'b1;
      send_exp(c, mk('0, 9'b000010000, 1'b1, 1'b1, 1'b0, N + 1, 0));

      // double error with correction enabled
      c = '0; c[9] = 1'b1; c[10] = 1'b1;
      send_model(c, 0);
      c = '0; c[0] = 1'b1; c[1] = 1'b1;
      send_model(c, 1);

      for (int n = 0; n < 1000; n++) begin
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         c = {model_crc(d), d};
         case ($urandom_range(0, 3))
            2: begin
               b    = $urandom_range(0, 136);
               c[b] = ~c[b];
            end
            3: begin
               b     = $urandom_range(0, 136);
               b2    = (b + $urandom_range(1, 136)) % 137;
               c[b]  = ~c[b];
               c[b2] = ~c[b2];
            end
            default: ;
         endcase
         send_model(c, $urandom_range(0, 2));
      end
      wait_idle();

      // detect-only instance
      c = '0; c[9] = 1'b1; c[10] = 1'b1;
      d = '0; d[0] = 1'b1; d[1] = 1'b1;
      nc_run(c, mk(d, 9'b011100100, 1'b1, 1'b0, 1'b1, N + 1, 0));
      c = '0; c[4] = 1'b1;
      nc_run(c, mk('0, 9'b000010000, 1'b1, 1'b0, 1'b1, N + 1, 0));
      c = '0;
      nc_run(c, mk('0, 9'b000000000, 1'b0, 1'b0, 1'b0, N + 1, 0));

      // reset during SYND aborts the codeword
      d = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      c = {model_crc(d), d};
      c[20] = ~c[20];
      send_model(c, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      void'(sb_q.pop_back());
      @(negedge clk);
      check_reset_outputs("midreset");
      reset_n = 1'b1;
      repeat (25) @(negedge clk);
      check_eq("no_emit_after_reset", 160'(o_valid), 160'(0));

      c = '0; c[9] = 1'b1;
      send_exp(c, mk('0, 9'b111001001, 1'b1, 1'b1, 1'b0, N + 2, 0));
      wait_idle();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
